// File: rtl/ps2_receiver_if.sv
// Result bus of the PS/2 receiver: received byte plus per-frame status strobes.
// master drives the bus, slave is the host-side consumer.
interface ps2_receiver_if;
  logic [7:0] data;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       bat_ok;
  logic       busy;

  modport master (
    output data,
    output data_valid,
    output parity_err,
    output frame_err,
    output bat_ok,
    output busy
  );

  modport slave (
    input data,
    input data_valid,
    input parity_err,
    input frame_err,
    input bat_ok,
    input busy
  );
endinterface

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver with clock glitch filter, frame timeout,
// host-inhibit abort and BAT (0xAA) completion flag.
module ps2_receiver #(
  parameter int FILTER_LEN    = 8,
  parameter int TIMEOUT_COUNT = 54000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  input  logic                  inhibit,
  ps2_receiver_if.master        rx
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_COUNT + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  logic          clk_s1;
  logic          clk_s2;
  logic          dat_s1;
  logic          dat_s2;

  logic [FW-1:0] fcnt;
  logic          fclk;
  logic          fall;

  logic [0:0]    state;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic [TW-1:0] to_cnt;

  logic [7:0]    data_q;
  logic          dv_q;
  logic          pe_q;
  logic          fe_q;
  logic          bat_q;
  logic          busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // fclk only follows clk_s2 after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt <= '0;
      fclk <= 1'b1;
      fall <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s2 != fclk) begin
        if (fcnt == FW'(FILTER_LEN - 1)) begin
          fclk <= clk_s2;
          fcnt <= '0;
          fall <= ~clk_s2;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      bat_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      dv_q  <= 1'b0;
      pe_q  <= 1'b0;
      fe_q  <= 1'b0;
      bat_q <= 1'b0;
      if (inhibit) begin
        state   <= IDLE;
        bit_cnt <= '0;
        to_cnt  <= '0;
        busy_q  <= 1'b0;
      end else begin
        unique case (1'b1)
          (state == IDLE): begin
            to_cnt <= '0;
            if (fall && !dat_s2) begin
              state   <= RECV;
              bit_cnt <= '0;
              busy_q  <= 1'b1;
            end
          end
          (state == RECV): begin
            if (fall) begin
              to_cnt  <= '0;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt < 4'd8) begin
                shift <= {dat_s2, shift[7:1]};
              end else if (bit_cnt == 4'd8) begin
                par_bit <= dat_s2;
              end else begin
                data_q  <= shift;
                state   <= IDLE;
                bit_cnt <= '0;
                busy_q  <= 1'b0;
                if (!dat_s2) begin
                  fe_q <= 1'b1;
                end else if (!(^{shift, par_bit})) begin
                  pe_q <= 1'b1;
                end else begin
                  dv_q  <= 1'b1;
                  bat_q <= (shift == 8'hAA);
                end
              end
            end else if (to_cnt == TW'(TIMEOUT_COUNT)) begin
              fe_q    <= 1'b1;
              state   <= IDLE;
              bit_cnt <= '0;
              to_cnt  <= '0;
              busy_q  <= 1'b0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign rx.data       = data_q;
  assign rx.data_valid = dv_q;
  assign rx.parity_err = pe_q;
  assign rx.frame_err  = fe_q;
  assign rx.bat_ok     = bat_q;
  assign rx.busy       = busy_q;

endmodule
